// File: rtl/traffic_phase_timer.sv
// Phase pacing for the UK traffic-light sequencer: watches the lights, times each
// phase and issues a single step pulse per phase, with pedestrian request handling.
module traffic_phase_timer #(
    parameter int CW          = 8,
    parameter int RED_TICKS   = 8,
    parameter int RA_TICKS    = 2,
    parameter int GREEN_TICKS = 8,
    parameter int MIN_GREEN   = 3,
    parameter int AMBER_TICKS = 3,
    parameter int PED_TICKS   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic red,
    input  logic amber,
    input  logic green,
    input  logic ped_req,
    output logic step,
    output logic ped_pending,
    output logic ped_walk,
    output logic illegal
);

    localparam logic [0:0] ST_COUNT = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    localparam logic [2:0] PH_R  = 3'b001;
    localparam logic [2:0] PH_RA = 3'b011;
    localparam logic [2:0] PH_G  = 3'b100;
    localparam logic [2:0] PH_A  = 3'b010;

    localparam logic [CW-1:0] ONE_T     = CW'(1);
    localparam logic [CW-1:0] RED_T     = CW'(RED_TICKS);
    localparam logic [CW-1:0] RED_PED_T = CW'(RED_TICKS + PED_TICKS);
    localparam logic [CW-1:0] RA_T      = CW'(RA_TICKS);
    localparam logic [CW-1:0] GREEN_T   = CW'(GREEN_TICKS);
    localparam logic [CW-1:0] MIN_G_T   = CW'(MIN_GREEN);
    localparam logic [CW-1:0] AMBER_T   = CW'(AMBER_TICKS);

    function automatic logic is_legal(input logic [2:0] l);
        case (l)
            PH_R, PH_RA, PH_G, PH_A: is_legal = 1'b1;
            default:                 is_legal = 1'b0;
        endcase
    endfunction

    logic [2:0]    lights_s;
    logic [2:0]    prev_lights_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] target_s;
    logic [0:0]    fsm_r;
    logic          change_s;
    logic          enter_red_s;
    logic          leave_red_s;
    logic          dwell_done_s;
    logic          step_r;
    logic          ped_pending_r;
    logic          ped_walk_r;
    logic          illegal_r;

    assign lights_s    = {green, amber, red};
    assign change_s    = (lights_s != prev_lights_r);
    assign enter_red_s = change_s && (lights_s == PH_R);
    assign leave_red_s = change_s && (prev_lights_r == PH_R);

    assign step        = step_r;
    assign ped_pending = ped_pending_r;
    assign ped_walk    = ped_walk_r;
    assign illegal     = illegal_r;

    // Dwell target for the phase currently shown; green reacts to a pending request each cycle
    always_comb begin
        target_s = ONE_T;
        case (lights_s)
            PH_R: begin
                if (ped_walk_r) target_s = RED_PED_T;
                else            target_s = RED_T;
            end
            PH_RA: target_s = RA_T;
            PH_G: begin
                if (ped_pending_r) target_s = MIN_G_T;
                else               target_s = GREEN_T;
            end
            PH_A:    target_s = AMBER_T;
            default: target_s = ONE_T;
        endcase
        dwell_done_s = (cnt_r >= (target_s - ONE_T));
    end

    // Change detection and illegal flag; a static illegal pattern is still flagged while counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lights_r <= 3'b000;
            illegal_r     <= 1'b0;
        end else begin
            prev_lights_r <= lights_s;
            if (change_s) begin
                illegal_r <= !is_legal(lights_s);
            end else if ((fsm_r == ST_COUNT) && !is_legal(lights_s)) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Dwell counter and single-shot step; WAIT blocks any second step until the lights move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            fsm_r  <= ST_COUNT;
            step_r <= 1'b0;
        end else if (change_s) begin
            cnt_r  <= '0;
            fsm_r  <= ST_COUNT;
            step_r <= 1'b0;
        end else if (!enable) begin
            step_r <= 1'b0;
        end else begin
            case (fsm_r)
                ST_COUNT: begin
                    if (dwell_done_s) begin
                        step_r <= 1'b1;
                        fsm_r  <= ST_WAIT;
                    end else begin
                        cnt_r  <= cnt_r + ONE_T;
                        step_r <= 1'b0;
                    end
                end
                ST_WAIT: step_r <= 1'b0;
                default: begin
                    fsm_r  <= ST_COUNT;
                    step_r <= 1'b0;
                end
            endcase
        end
    end

    // Pedestrian latch: a request on red entry goes straight to walk, otherwise it waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending_r <= 1'b0;
            ped_walk_r    <= 1'b0;
        end else if (enter_red_s) begin
            ped_walk_r    <= ped_pending_r | ped_req;
            ped_pending_r <= 1'b0;
        end else begin
            if (leave_red_s) ped_walk_r <= 1'b0;
            if (ped_req)     ped_pending_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: the bench plays the sequencer, advancing
// the lights whenever it sees step, and checks dwell lengths and flag behaviour.
module tb_traffic_phase_timer;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic red, amber, green;
    logic ped_req;
    logic step, ped_pending, ped_walk, illegal;

    int tests_run = 0;
    int tests_failed = 0;
    int k;
    int highs;

    traffic_phase_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .red        (red),
        .amber      (amber),
        .green      (green),
        .ped_req    (ped_req),
        .step       (step),
        .ped_pending(ped_pending),
        .ped_walk   (ped_walk),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lights(input logic [2:0] gar);
        {green, amber, red} = gar;
    endtask

    // Ticks until step is seen; returns the edge index it appeared after
    task automatic wait_step(input int start_k, output int edges);
        edges = start_k;
        for (int i = 0; i < 64; i++) begin
            tick();
            edges++;
            if (step === 1'b1) break;
        end
    endtask

    // Shows a new phase, takes the change edge, then measures its dwell
    task automatic phase(input string tag, input logic [2:0] gar, input int exp);
        int e;
        set_lights(gar);
        tick();
        wait_step(0, e);
        check(tag, e, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        ped_req = 1'b0;
        set_lights(3'b001);
        tick();
        tick();
        check("rst_step", step, 0);
        check("rst_pending", ped_pending, 0);
        check("rst_walk", ped_walk, 0);
        check("rst_illegal", illegal, 0);

        // Test 1: release with red shown; first edge is the change edge
        rst_n = 1'b1;
        tick();
        check("t1_edge0_step", step, 0);
        wait_step(0, k);
        check("t1_red_dwell", k, 8);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step === 1'b1) highs++;
        end
        check("t1_no_second_step", highs, 0);

        // Test 2: closed loop without pedestrians
        phase("t2_ra", 3'b011, 2);
        phase("t2_g", 3'b100, 8);
        phase("t2_a", 3'b010, 3);
        phase("t2_r", 3'b001, 8);
        phase("t2_ra2", 3'b011, 2);

        // Test 3: request on green edge 1 cuts green to MIN_GREEN and extends next red
        set_lights(3'b100);
        tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("t3_pending_set", ped_pending, 1);
        wait_step(1, k);
        check("t3_green_short", k, 3);
        phase("t3_a", 3'b010, 3);
        check("t3_pending_hold", ped_pending, 1);
        set_lights(3'b001);
        tick();
        check("t3_walk_on", ped_walk, 1);
        check("t3_pending_clr", ped_pending, 0);
        wait_step(0, k);
        check("t3_red_long", k, 12);
        set_lights(3'b011);
        tick();
        check("t3_walk_off", ped_walk, 0);
        wait_step(0, k);
        check("t3_ra", k, 2);

        // Test 4: late request on green edge 6 triggers step on edge 7
        set_lights(3'b100);
        tick();
        for (int i = 0; i < 5; i++) tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("t4_no_step_e6", step, 0);
        check("t4_pending", ped_pending, 1);
        tick();
        check("t4_step_e7", step, 1);
        phase("t4_a", 3'b010, 3);
        set_lights(3'b001);
        tick();
        check("t4_walk_on", ped_walk, 1);
        wait_step(0, k);
        check("t4_red_long", k, 12);

        // Test 5: illegal pattern recovers via a step one edge after the change
        set_lights(3'b111);
        tick();
        check("t5_illegal_set", illegal, 1);
        check("t5_edge0_step", step, 0);
        tick();
        check("t5_step_e1", step, 1);
        tick();
        check("t5_step_drop", step, 0);
        check("t5_illegal_hold", illegal, 1);
        set_lights(3'b001);
        tick();
        check("t5_illegal_clr", illegal, 0);
        check("t5_walk_off", ped_walk, 0);
        wait_step(0, k);
        check("t5_red", k, 8);

        // Test 6: freeze the red count after edge 4, resume, then reset mid-green
        phase("t6_ra", 3'b011, 2);
        phase("t6_g", 3'b100, 8);
        phase("t6_a", 3'b010, 3);
        set_lights(3'b001);
        tick();
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step === 1'b1) highs++;
        end
        check("t6_frozen_no_step", highs, 0);
        enable = 1'b1;
        wait_step(0, k);
        check("t6_resume", k, 4);

        phase("t6_ra2", 3'b011, 2);
        set_lights(3'b100);
        tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        wait_step(1, k);
        check("t6_green_short", k, 3);
        check("t6_pre_rst_pending", ped_pending, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_step", step, 0);
        check("t6_rst_pending", ped_pending, 0);
        check("t6_rst_walk", ped_walk, 0);
        check("t6_rst_illegal", illegal, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_edge0", step, 0);
        wait_step(0, k);
        check("t6_post_green", k, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Upstream pacing stage for the UK traffic-light sequencer.
- Watches the sequencer's red/amber/green outputs and decides how long each phase lasts.
- Issues a one-cycle `step` pulse that the sequencer uses as its advance enable.
- Adds a latched pedestrian request that shortens green and extends red, with a walk indication while the request is served.

Parameters:
- CW, 8, width of dwell counter; every dwell value must be ≥1 and < 2^CW
- RED_TICKS, 8, red dwell in clock cycles
- RA_TICKS, 2, red+amber dwell
- GREEN_TICKS, 8, green dwell without a pedestrian request
- MIN_GREEN, 3, minimum green dwell when a pedestrian request is pending (≤ GREEN_TICKS)
- AMBER_TICKS, 3, amber dwell
- PED_TICKS, 4, extra red dwell added while serving a pedestrian request

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = timing runs; 0 = counter frozen, no step issued
- red  in  1  sequencer red output
- amber  in  1  sequencer amber output
- green  in  1  sequencer green output
- ped_req  in  1  pedestrian button, level or pulse, sampled each edge
- step  out  1  registered one-cycle advance pulse to sequencer
- ped_pending  out  1  registered; request latched, not yet served
- ped_walk  out  1  registered; high while the red phase serving a request is active
- illegal  out  1  registered; lights decode to no legal phase

Behaviour:
- Phase decode of {green,amber,red}: 001=R, 011=RA, 100=G, 010=A; any other value is ILLEGAL.
- Reset (async, rst_n=0): prev_lights=000, cnt=0, fsm=COUNT, step=0, ped_pending=0, ped_walk=0, illegal=0.
- Change detect: on each edge, compare {g,a,r} with prev_lights, then update prev_lights. This runs regardless of enable.
- On a change edge:
  - cnt←0, fsm←COUNT, step←0.
  - illegal←(new value is ILLEGAL).
  - Entering R: ped_walk←ped_pending|ped_req, and ped_pending←0.
  - Leaving R: ped_walk←0.
- Target dwell per phase:
  - R: RED_TICKS, plus PED_TICKS if ped_walk.
  - RA: RA_TICKS.
  - A: AMBER_TICKS.
  - ILLEGAL: 1.
  - G: GREEN_TICKS, or MIN_GREEN if ped_pending.
  - A request arriving mid-green is re-evaluated every cycle. If cnt already ≥ MIN_GREEN-1, step issues on the next edge.
- FSM (no change edge, enable=1):
  - COUNT: if cnt ≥ target-1, step←1 and fsm←WAIT; else cnt←cnt+1.
  - WAIT: step←0; stay in WAIT until a change edge. No further step is issued, so exactly one step per phase.
- Timing consequence: step is high in the cycle following the edge DWELL edges after the change edge (change edge = edge 0).
- enable=0:
  - cnt and fsm hold, step←0.
  - Change detection still operates.
  - On re-enable, counting resumes from the held cnt. A step pending in COUNT is issued only once enabled.
- Pedestrian latch:
  - ped_req=1 on any edge sets ped_pending, except on the edge entering R, where the request is absorbed into ped_walk.
  - ped_req during R (after entry) stays pending for the next cycle.
  - ped_pending never clears except on R entry or reset.
- ILLEGAL handling: a step pulse issues one edge after the change edge, so the sequencer's default-to-red recovers. illegal clears on the next change edge to a legal value.
- A constant illegal value from reset (e.g. 000 vs prev 000) counts as no change. It is still flagged: illegal is also set whenever the current decode is ILLEGAL while in COUNT, with target 1.
- Reset mid-phase clears all state immediately, with no step glitch. The first edge after release sees a change if the lights are not 000.

Test Plan:
1. Reset release, lights held 001, enable=1, no ped: step high exactly one cycle after edge 8, then stays 0 for ≥20 cycles while lights unchanged.
2. Closed loop with the sequencer, no ped: step issues for R/RA/G/A after 8/2/8/3 edges from each change edge; sequence 001→011→100→010→001 repeats.
3. ped_req pulse at G edge 1: ped_pending=1, step after edge 3. Next R entry: ped_walk=1, ped_pending=0, red dwell 12 edges, ped_walk=0 on the RA change edge.
4. ped_req pulse at G edge 6 (cnt > MIN_GREEN-1): step on the following edge, not edge 8.
5. Lights forced 111: illegal=1 and step pulse one edge after the change. Lights then 001: illegal=0, normal 8-edge red.
6. enable=0 at R edge 4 for 10 cycles, then 1: no step while low; step 4 edges after re-enable. rst_n=0 mid-G clears step, ped_pending, ped_walk and illegal asynchronously.
